// File: rtl/rot_frame_writer.sv
// rot_frame_writer: streams a 32x32 raster frame into a frame buffer, rotating
// write addresses by 0/90/180/270 degrees. Rotation support is compiled in
// with the ORIENT_ROT_EN macro; without it every frame is written in raster order.
module rot_frame_writer #(
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       orient,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             wr_en,
  output logic [9:0]       wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned DIM_W  = 5;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DIM_W-1:0]  r, c;
  logic              accept;
  logic              last_px;
  logic [ADDR_W-1:0] addr_map;

  assign in_ready = (state == WRITE) & ~abort;
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign last_px  = (r == DIM_W'(31)) & (c == DIM_W'(31));

`ifdef ORIENT_ROT_EN
  logic [1:0] orient_q;

  // Raster (r,c) to rotated frame-buffer address
  always_comb begin
    addr_map = {r, c};
    case (orient_q)
      2'd1:    addr_map = {c, ~r};
      2'd2:    addr_map = {~r, ~c};
      2'd3:    addr_map = {~c, r};
      default: addr_map = {r, c};
    endcase
  end

  // Orientation is captured once per frame, at start
  always_ff @(posedge clk) begin
    if (!reset) begin
      orient_q <= 2'd0;
    end else if (state == IDLE && start) begin
      orient_q <= orient;
    end
  end
`else
  // Orientation port is kept for a stable port list but has no effect here
  logic unused_orient;
  assign unused_orient = ^orient;

  // Raster order only
  always_comb begin
    addr_map = {r, c};
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (accept && last_px) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Raster position counters: column fastest, row advances on column wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      r <= '0;
      c <= '0;
    end else if (state == IDLE && start) begin
      r <= '0;
      c <= '0;
    end else if (accept) begin
      c <= c + DIM_W'(1);
      if (c == DIM_W'(31)) r <= r + DIM_W'(1);
    end
  end

  // Registered write port; address/data hold between writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= accept;
      frame_done <= accept & last_px;
      if (accept) begin
        wr_addr <= addr_map;
        wr_data <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_rot_frame_writer.sv
// Scoreboard bench for rot_frame_writer: the driver predicts each write into a
// queue, the monitor pops and compares whenever wr_en is seen.
module tb_rot_frame_writer;

  localparam int unsigned PIX_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, abort, in_valid;
  logic [1:0]       orient;
  logic [PIX_W-1:0] in_pixel;
  logic             in_ready, wr_en, busy, frame_done;
  logic [9:0]       wr_addr;
  logic [PIX_W-1:0] wr_data;

  rot_frame_writer #(.PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .orient(orient),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]       addr;
    logic [PIX_W-1:0] data;
    logic             last;
    int               cyc;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] wlog[$];
  int checks = 0, errors = 0;
  int cyc = 0, fd_cnt = 0;
  logic [9:0]       hold_addr = '0;
  logic [PIX_W-1:0] hold_data = '0;

  // model state: 0 idle, 1 write, 2 done
  int         ms = 0;
  logic [4:0] mr = '0, mc = '0;
  logic [1:0] mo = '0;
  int         macc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] map(input logic [4:0] r, input logic [4:0] c,
                                     input logic [1:0] o);
`ifdef ORIENT_ROT_EN
    case (o)
      2'd1:    return {c, ~r};
      2'd2:    return {~r, ~c};
      2'd3:    return {~c, r};
      default: return {r, c};
    endcase
`else
    return {r, c} ^ 10'(o & 2'b00);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e.addr));
        chk("wr_data", int'(wr_data), int'(e.data));
        chk("frame_done_with_write", int'(frame_done), int'(e.last));
        chk("write_latency", cyc - e.cyc, 1);
      end
      wlog.push_back(wr_addr);
      hold_addr = wr_addr;
      hold_data = wr_data;
    end else begin
      chk("stray_frame_done", int'(frame_done), 0);
      chk("hold_addr", int'(wr_addr), int'(hold_addr));
      chk("hold_data", int'(wr_data), int'(hold_data));
    end
    if (frame_done) fd_cnt++;
  end

  // One driven cycle: inputs applied after posedge, model updated at negedge
  task automatic step(input logic v, input logic st, input logic ab, input logic [1:0] o);
    exp_t e;
    in_valid = v; start = st; abort = ab; orient = o;
    in_pixel = PIX_W'(macc * 7 + 3);
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(ms == 1 && !ab));
    chk("busy", int'(busy), int'(ms != 0));
    case (ms)
      0: if (st) begin mo = o; mr = '0; mc = '0; macc = 0; ms = 1; end
      1: begin
        if (ab) ms = 0;
        else if (v) begin
          e.addr = map(mr, mc, mo);
          e.data = in_pixel;
          e.last = (mr == 5'd31 && mc == 5'd31);
          e.cyc  = cyc;
          sb.push_back(e);
          macc++;
          if (e.last) ms = 2;
          mc = mc + 5'd1;
          if (mc == 5'd0) mr = mr + 5'd1;
        end
      end
      default: ms = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Start a frame and stream it; mode 1 toggles in_valid and jabs start/orient
  task automatic run_frame(input logic [1:0] o, input int mode);
    int budget = 0;
    wlog.delete();
    step(1'b0, 1'b1, 1'b0, o);
    while (ms != 0 && budget < 5000) begin
      if (mode == 0) step(1'b1, 1'b0, 1'b0, o);
      else step(logic'(budget % 2 == 0), logic'(budget % 97 == 5), 1'b0, 2'(budget));
      budget++;
    end
    chk("frame_timeout", int'(budget >= 5000), 0);
    step(1'b0, 1'b0, 1'b0, o);
    step(1'b0, 1'b0, 1'b0, o);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; start = 1'b0; abort = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    ms = 0; mr = '0; mc = '0; mo = '0; macc = 0;
    hold_addr = '0; hold_data = '0;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
  endtask

  initial begin
    int fd0;
    bit seen[1024];
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    orient = 2'd0; in_pixel = '0;
    @(posedge clk); #1;
    do_reset();

    // Raster frame, in_valid held high
    fd0 = fd_cnt;
    run_frame(2'd0, 0);
    chk("o0_writes", wlog.size(), 1024);
    chk("o0_first", int'(wlog[0]), 0);
    chk("o0_second", int'(wlog[1]), 1);
    chk("o0_last", int'(wlog[1023]), 1023);
    chk("o0_frame_done_cnt", fd_cnt - fd0, 1);

    // 270 degrees
    run_frame(2'd3, 0);
`ifdef ORIENT_ROT_EN
    chk("o3_w0", int'(wlog[0]), 992);
    chk("o3_w1", int'(wlog[1]), 960);
    chk("o3_w2", int'(wlog[2]), 928);
    chk("o3_w32", int'(wlog[32]), 993);
    chk("o3_last", int'(wlog[1023]), 31);
`else
    chk("o3_raster_w0", int'(wlog[0]), 0);
    chk("o3_raster_w1", int'(wlog[1]), 1);
    chk("o3_raster_w32", int'(wlog[32]), 32);
    chk("o3_raster_last", int'(wlog[1023]), 1023);
`endif

    // 90 and 180 degrees
    run_frame(2'd1, 0);
`ifdef ORIENT_ROT_EN
    chk("o1_w0", int'(wlog[0]), 31);
    chk("o1_w1", int'(wlog[1]), 63);
`else
    chk("o1_raster_w0", int'(wlog[0]), 0);
`endif
    run_frame(2'd2, 0);
`ifdef ORIENT_ROT_EN
    chk("o2_w0", int'(wlog[0]), 1023);
    chk("o2_last", int'(wlog[1023]), 0);
`else
    chk("o2_raster_last", int'(wlog[1023]), 1023);
`endif

    // Toggled in_valid, stray start pulses and orient changes mid-frame
    fd0 = fd_cnt;
    run_frame(2'd0, 1);
    chk("tog_writes", wlog.size(), 1024);
    foreach (seen[i]) seen[i] = 1'b0;
    begin
      int dups = 0;
      foreach (wlog[i]) begin
        if (seen[wlog[i]]) dups++;
        seen[wlog[i]] = 1'b1;
      end
      chk("tog_duplicates", dups, 0);
    end
    chk("tog_frame_done_cnt", fd_cnt - fd0, 1);

    // Abort after 100 accepts
    fd0 = fd_cnt;
    wlog.delete();
    step(1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    chk("abort_writes", wlog.size(), 100);
    chk("abort_no_frame_done", fd_cnt - fd0, 0);
    chk("abort_drained", sb.size(), 0);
    run_frame(2'd0, 0);
    chk("post_abort_first", int'(wlog[0]), 0);
    chk("post_abort_writes", wlog.size(), 1024);

    // Reset mid-frame
    step(1'b0, 1'b1, 1'b0, 2'd3);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 2'd3);
    do_reset();
    run_frame(2'd0, 0);
    chk("post_reset_first", int'(wlog[0]), 0);
    chk("post_reset_last", int'(wlog[1023]), 1023);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
